// File: rtl/seq_match_pkg.sv
// Shared encodings for the seq_match scan controller and its pattern detector.
package seq_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  // Mk = k pattern symbols matched so far
  typedef enum logic [1:0] {
    M0 = 2'd0,
    M1 = 2'd1,
    M2 = 2'd2,
    M3 = 2'd3
  } det_state_e;

  // Pattern layout: [1:0] first symbol, [3:2] second, [5:4] third
  localparam logic [5:0] DEFAULT_PAT = 6'b11_10_01;

endpackage

// File: rtl/seq_match_det.sv
// Programmable 3-symbol detector with pattern register.
// hit is a registered one-cycle pulse after each step that lands in M3;
// hit_next is the same condition one cycle early so the controller can
// count and stop on the edge that enters M3.
module seq_match_det
  import seq_match_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       step,
  input  logic [1:0] sym,
  input  logic       pat_we,
  input  logic [5:0] pat,
  output logic       hit,
  output logic       hit_next
);

  det_state_e state_q, state_d;
  logic [5:0] pat_q, pat_d;
  logic       hit_q, hit_d;

  // Next-state: fixed fallback to M1 on a first-symbol hit, else M0; M3 behaves as M0
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hit_d   = 1'b0;
    if (pat_we) begin
      pat_d = pat;
    end
    if (clr) begin
      state_d = M0;
    end else if (step) begin
      unique case (state_q)
        M0, M3: state_d = (sym == pat_q[1:0]) ? M1 : M0;
        M1:     state_d = (sym == pat_q[3:2]) ? M2 :
                          (sym == pat_q[1:0]) ? M1 : M0;
        M2:     state_d = (sym == pat_q[5:4]) ? M3 :
                          (sym == pat_q[1:0]) ? M1 : M0;
        default: state_d = M0;
      endcase
      hit_d = (state_d == M3);
    end
  end

  // Detector state, pattern and hit pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= M0;
      pat_q   <= DEFAULT_PAT;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hit_q   <= hit_d;
    end
  end

  assign hit      = hit_q;
  assign hit_next = hit_d;

endmodule

// File: rtl/seq_match_ctrl.sv
// Scan controller: accepts start/scan_len, pulls scan_len symbols over
// valid/ready, drives seq_match_det and counts matches (saturating).
// Optional build macro STOP_ON_MATCH_EN: end the scan on the first match and
// report its 0-based symbol index on match_pos.
module seq_match_ctrl
  import seq_match_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] scan_len,
  input  logic             cfg_we,
  input  logic [5:0]       cfg_pat,
  input  logic             in_valid,
  input  logic [1:0]       in_sym,
  output logic             in_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
`ifdef STOP_ON_MATCH_EN
  ,
  output logic [LEN_W-1:0] match_pos
`endif
);

  ctrl_state_e      state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef STOP_ON_MATCH_EN
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] pos_q, pos_d;
`endif

  logic consume;
  logic start_ok;
  logic det_pat_we;
  logic det_hit;
  logic det_hit_next;

  // in_ready_q is high exactly when state_q==RUN
  assign consume    = in_valid & in_ready_q;
  assign start_ok   = (state_q == IDLE) & start;
  assign det_pat_we = (state_q == IDLE) & cfg_we;

  seq_match_det u_det (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_ok),
    .step     (consume),
    .sym      (in_sym),
    .pat_we   (det_pat_we),
    .pat      (cfg_pat),
    .hit      (det_hit),
    .hit_next (det_hit_next)
  );

  // Control FSM next-state, remaining/match counters and registered outputs
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
`ifdef STOP_ON_MATCH_EN
    idx_d   = idx_q;
    pos_d   = pos_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
`ifdef STOP_ON_MATCH_EN
          idx_d = '0;
          pos_d = '1;
`endif
          if (scan_len != '0) begin
            state_d = RUN;
            rem_d   = scan_len;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (consume) begin
          rem_d = rem_q - 1'b1;
          if (det_hit_next && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
`ifdef STOP_ON_MATCH_EN
          idx_d = idx_q + 1'b1;
          if (det_hit_next) begin
            pos_d   = idx_q;
            state_d = DONE;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  // Control state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef STOP_ON_MATCH_EN
      idx_q      <= '0;
      pos_q      <= '1;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef STOP_ON_MATCH_EN
      idx_q      <= idx_d;
      pos_q      <= pos_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match     = det_hit;
  assign match_cnt = cnt_q;
`ifdef STOP_ON_MATCH_EN
  assign match_pos = pos_q;
`endif

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: one default-width instance plus a
// CNT_W=2 instance sharing stimulus for the saturation case.
module tb_seq_match_ctrl;

  localparam int LEN_W = 8;
`ifdef STOP_ON_MATCH_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] scan_len;
  logic             cfg_we;
  logic [5:0]       cfg_pat;
  logic             in_valid;
  logic [1:0]       in_sym;

  logic             in_ready, match, busy, done;
  logic [7:0]       match_cnt;
  logic             in_ready2, match2, busy2, done2;
  logic [1:0]       match_cnt2;
`ifdef STOP_ON_MATCH_EN
  logic [LEN_W-1:0] match_pos, match_pos2;
`endif

  always #5 clk = ~clk;

  seq_match_ctrl #(.LEN_W(LEN_W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .scan_len(scan_len),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .in_valid(in_valid), .in_sym(in_sym),
    .in_ready(in_ready), .match(match), .match_cnt(match_cnt),
    .busy(busy), .done(done)
`ifdef STOP_ON_MATCH_EN
    , .match_pos(match_pos)
`endif
  );

  seq_match_ctrl #(.LEN_W(LEN_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .scan_len(scan_len),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .in_valid(in_valid), .in_sym(in_sym),
    .in_ready(in_ready2), .match(match2), .match_cnt(match_cnt2),
    .busy(busy2), .done(done2)
`ifdef STOP_ON_MATCH_EN
    , .match_pos(match_pos2)
`endif
  );

  typedef struct packed {logic v; logic [1:0] s; logic m;} item_t;
  typedef struct packed {logic match; logic done; logic busy;} exp_t;

  item_t stim[$];
  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [1:0] s, input logic m);
    item_t it;
    it.v = v; it.s = s; it.m = m;
    stim.push_back(it);
  endtask

  task automatic cfg_idle(input logic [5:0] p);
    cfg_we = 1'b1; cfg_pat = p;
    tick();
    cfg_we = 1'b0;
  endtask

  // Drive one scan from the stim list; m marks symbols expected to complete a match
  task automatic run_scan(input string name, input int len, input bit cfg_with_start,
                          input logic [5:0] new_pat, input bit cfg_in_run);
    int   consumed;
    int   hits;
    int   first_idx;
    bit   stopped;
    exp_t e;
    consumed = 0; hits = 0; first_idx = -1; stopped = 1'b0;
    cfg_we   = cfg_with_start;
    cfg_pat  = new_pat;
    start    = 1'b1;
    scan_len = len[LEN_W-1:0];
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    if (len == 0) begin
      chk({name, "_zero_done"}, 32'(done), 32'd1);
      chk({name, "_zero_busy"}, 32'(busy), 32'd0);
      chk({name, "_zero_ready"}, 32'(in_ready), 32'd0);
      stopped = 1'b1;
    end else begin
      chk({name, "_busy"}, 32'(busy), 32'd1);
      chk({name, "_ready"}, 32'(in_ready), 32'd1);
      foreach (stim[i]) begin
        if (!stopped) begin
          in_valid = stim[i].v;
          in_sym   = stim[i].s;
          if (cfg_in_run && i == 0) begin
            cfg_we  = 1'b1;
            cfg_pat = 6'b01_01_01;
          end
          e.match = stim[i].v & stim[i].m;
          if (stim[i].v) begin
            consumed++;
            if (stim[i].m) begin
              hits++;
              if (first_idx < 0) first_idx = consumed - 1;
            end
          end
          e.done = stim[i].v & ((consumed == len) | (STOP & stim[i].m));
          e.busy = ~e.done;
          sb.push_back(e);
          tick();
          in_valid = 1'b0;
          cfg_we   = 1'b0;
          e = sb.pop_front();
          chk($sformatf("%s_match_%0d", name, i), 32'(match), 32'(e.match));
          chk($sformatf("%s_done_%0d", name, i), 32'(done), 32'(e.done));
          chk($sformatf("%s_busy_%0d", name, i), 32'(busy), 32'(e.busy));
          chk($sformatf("%s_ready_%0d", name, i), 32'(in_ready), 32'(e.busy));
          chk($sformatf("%s_match2_%0d", name, i), 32'(match2), 32'(e.match));
          chk($sformatf("%s_done2_%0d", name, i), 32'(done2), 32'(e.done));
          if (e.done) stopped = 1'b1;
        end
      end
    end
    chk({name, "_finished"}, 32'(stopped), 32'd1);
    tick();
    chk({name, "_idle_done"}, 32'(done), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_cnt"}, 32'(match_cnt), 32'(hits));
    chk({name, "_cnt2"}, 32'(match_cnt2), 32'((hits > 3) ? 3 : hits));
`ifdef STOP_ON_MATCH_EN
    chk({name, "_pos"}, 32'(match_pos), (first_idx < 0) ? 32'hFF : 32'(first_idx));
`endif
    stim.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; scan_len = '0; cfg_we = 1'b0; cfg_pat = '0;
    in_valid = 1'b0; in_sym = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Default pattern 01,10,11
    add(1, 2'b01, 0); add(1, 2'b10, 0); add(1, 2'b11, 1);
    add(1, 2'b00, 0); add(1, 2'b01, 0); add(1, 2'b10, 0);
    run_scan("s1", 6, 0, '0, 0);

    add(1, 2'b01, 0); add(1, 2'b01, 0); add(1, 2'b10, 0); add(1, 2'b11, 1);
    add(1, 2'b01, 0); add(1, 2'b10, 0); add(1, 2'b11, 1);
    run_scan("s2", 7, 0, '0, 0);

    // Pattern 01,01,10: fallback rule is not a full overlap search
    cfg_idle(6'b10_01_01);
    add(1, 2'b01, 0); add(1, 2'b01, 0); add(1, 2'b01, 0); add(1, 2'b10, 0);
    run_scan("ovl", 4, 0, '0, 0);

    run_scan("zero", 0, 0, '0, 0);

    // Gaps: invalid cycles carry symbols that would break the pattern if consumed
    add(1, 2'b01, 0); add(0, 2'b11, 0); add(0, 2'b10, 0);
    add(1, 2'b01, 0); add(1, 2'b10, 1); add(1, 2'b00, 0);
    run_scan("gap", 4, 0, '0, 0);

    // in_valid in IDLE is not consumed and match_cnt holds
    in_valid = 1'b1; in_sym = 2'b01;
    tick();
    in_valid = 1'b0;
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_hold_cnt", 32'(match_cnt), 32'd1);

    // Pattern written on the start cycle; write during RUN is ignored
    for (int i = 0; i < 5; i++) add(1, 2'b00, (i == 2) ? 1'b1 : 1'b0);
    run_scan("s3", 5, 1, 6'b00_00_00, 1);

    for (int i = 0; i < 15; i++) add(1, 2'b00, (i % 3 == 2) ? 1'b1 : 1'b0);
    run_scan("sat", 15, 0, '0, 0);

    // Reset mid-scan after two consumes with a non-default pattern loaded
    start = 1'b1; scan_len = 8'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_sym = 2'b00;
    tick(); tick();
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_ready", 32'(in_ready), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    chk("rr_cnt", 32'(match_cnt), 32'd0);
    tick();
    chk("rr_no_done", 32'(done), 32'd0);

    // Default pattern must be back in force
    add(1, 2'b01, 0); add(1, 2'b10, 0); add(1, 2'b11, 1);
    add(1, 2'b00, 0); add(1, 2'b01, 0); add(1, 2'b10, 0);
    run_scan("s1b", 6, 0, '0, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("idle_rst_cnt", 32'(match_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
